soc_design_led_pwm_drv: RTL

//   Downstream consumer of the LED PIO out_port. Takes the 8-bit LED pattern and drives
//   the board LED pins with global PWM dimming and per-LED blink. Carries its own

---
 rtl/soc_design_led_pkg.sv | 21 ++
 rtl/soc_design_led_pwm_tick.sv | 39 +++
 rtl/soc_design_led_pwm_drv.sv | 134 +++++++++++++
 3 files changed

// File: rtl/soc_design_led_pkg.sv
// LED PWM driver shared definitions: register map, reset values, width defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package soc_design_led_pkg;

  // Width defaults for the driver and its tick generator
  localparam int LED_W_DEF   = 8;
  localparam int PRESC_W_DEF = 16;
  localparam int PWM_W_DEF   = 8;

  // Avalon word addresses of the configuration registers
  localparam logic [1:0] ADDR_PRESC      = 2'd0;
  localparam logic [1:0] ADDR_DUTY       = 2'd1;
  localparam logic [1:0] ADDR_BLINK_MASK = 2'd2;
  localparam logic [1:0] ADDR_BLINK_HALF = 2'd3;

  // Reset values: full brightness, blinking LEDs start in the visible phase
  localparam int   DUTY_RST        = 255;
  localparam logic BLINK_PHASE_RST = 1'b1;

endpackage

// File: rtl/soc_design_led_pwm_tick.sv
// Prescaler plus PWM frame counter; tick/frame_end are combinational from counter state.
// Latency: counters restart from 0 on the edge after clr; tick appears when presc_cnt==presc.
// Backpressure: none; clr suppresses tick/frame_end in its cycle so a config write wins.
module soc_design_led_pwm_tick
  import soc_design_led_pkg::*;
#(
  parameter int PRESC_W = PRESC_W_DEF,
  parameter int PWM_W   = PWM_W_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [PRESC_W-1:0] presc,
  input  logic               clr,
  output logic               tick,
  output logic               frame_end,
  output logic [PWM_W-1:0]   pwm_cnt
);

  logic [PRESC_W-1:0] presc_cnt;

  // A tick in a clearing cycle is dropped so nothing downstream advances
  assign tick      = (presc_cnt == presc) & ~clr;
  assign frame_end = tick & (pwm_cnt == {PWM_W{1'b1}});

  // Prescaler runs 0..presc and wraps; PWM counter advances once per tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
    end else if (clr) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/soc_design_led_pwm_drv.sv
// LED pin driver: global PWM dimming and per-LED blink on the PIO pattern, Avalon-MM config.
// Latency: led_out registered, one clk after led_pattern / counter state; reads are comb.
// Backpressure: none; zero-wait slave. Optional LED_FADE_EN: duty_eff ramps toward DUTY.
module soc_design_led_pwm_drv
  import soc_design_led_pkg::*;
#(
  parameter int LED_W   = LED_W_DEF,
  parameter int PRESC_W = PRESC_W_DEF,
  parameter int PWM_W   = PWM_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [LED_W-1:0] led_pattern,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [LED_W-1:0] led_out
);

  logic [PRESC_W-1:0] presc;
  logic [PWM_W-1:0]   duty;
  logic [LED_W-1:0]   blink_mask;
  logic [15:0]        blink_half;
  logic [15:0]        blink_cnt;
  logic               blink_phase;
  logic [PWM_W-1:0]   duty_eff;
  logic [PWM_W-1:0]   pwm_cnt;
  logic               tick;
  logic               frame_end;
  logic               pwm_on;
  logic               wr;
  logic               wr_presc;
  logic               wr_half;
  logic               unused_wdata;

  assign wr       = chipselect & ~write_n;
  assign wr_presc = wr & (address == ADDR_PRESC);
  assign wr_half  = wr & (address == ADDR_BLINK_HALF);

  // Upper write-data bits beyond each register's width are simply dropped
  assign unused_wdata = &{1'b0, writedata};

  soc_design_led_pwm_tick #(
    .PRESC_W (PRESC_W),
    .PWM_W   (PWM_W)
  ) u_tick (
    .clk       (clk),
    .reset_n   (reset_n),
    .presc     (presc),
    .clr       (wr_presc),
    .tick      (tick),
    .frame_end (frame_end),
    .pwm_cnt   (pwm_cnt)
  );

  // Configuration register file
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc      <= '0;
      duty       <= PWM_W'(DUTY_RST);
      blink_mask <= '0;
      blink_half <= '0;
    end else if (wr) begin
      case (address)
        ADDR_PRESC:      presc      <= writedata[PRESC_W-1:0];
        ADDR_DUTY:       duty       <= writedata[PWM_W-1:0];
        ADDR_BLINK_MASK: blink_mask <= writedata[LED_W-1:0];
        default:         blink_half <= writedata[15:0];
      endcase
    end
  end

`ifdef LED_FADE_EN
  // Effective duty walks one step per frame toward the programmed DUTY
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_eff <= PWM_W'(DUTY_RST);
    end else if (frame_end) begin
      if (duty_eff < duty)      duty_eff <= duty_eff + 1'b1;
      else if (duty_eff > duty) duty_eff <= duty_eff - 1'b1;
    end
  end
`else
  assign duty_eff = duty;
`endif

  // Read mux; bits outside a register read as zero
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_PRESC: readdata[PRESC_W-1:0] = presc;
      ADDR_DUTY: begin
        readdata[PWM_W-1:0] = duty;
`ifdef LED_FADE_EN
        readdata[2*PWM_W-1:PWM_W] = duty_eff;
`endif
      end
      ADDR_BLINK_MASK: readdata[LED_W-1:0] = blink_mask;
      default:         readdata[15:0]      = blink_half;
    endcase
  end

  // Blink timer: counts frames, toggles phase after blink_half+1 frames; a write restarts it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= BLINK_PHASE_RST;
    end else if (wr_half) begin
      blink_cnt <= '0;
    end else if (frame_end) begin
      if (blink_cnt == blink_half) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Full-scale duty is constant on rather than on for 255 of 256 slots
  assign pwm_on = (duty_eff == {PWM_W{1'b1}}) | (pwm_cnt < duty_eff);

  // Registered pin drive
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_out <= '0;
    end else begin
      led_out <= led_pattern & {LED_W{pwm_on}} & (~blink_mask | {LED_W{blink_phase}});
    end
  end

endmodule
